// File: rtl/nmi_rd_cache.sv
// Direct-mapped, write-through, one-word-line read cache on the native memory interface.
// Optional hit/miss statistics counters are built when NMI_RD_CACHE_STAT_EN is defined.
module nmi_rd_cache #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] CACHE_BASE = 32'h0000_0000,
  parameter logic [31:0] CACHE_MASK = 32'hF000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_wstrb_i,
  output logic [31:0] s_rdata_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic [31:0] m_rdata_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_t;

  function automatic logic is_cacheable(input logic [31:0] addr);
    return (addr & CACHE_MASK) == CACHE_BASE;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        req_addr_q;
  logic [31:0]        req_wdata_q;
  logic [3:0]         req_wstrb_q;
  logic               drop_q;
  logic [DEPTH-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [DEPTH];
  logic [31:0]        data_mem [DEPTH];

  logic [IDX_W-1:0]   s_idx, r_idx;
  logic [TAG_W-1:0]   s_tag, r_tag;
  logic               s_is_rd, s_hit, r_hit;
  logic               accept, fill_en, merge_en, hit_evt, miss_evt;
  logic [31:0]        merged;

  assign s_idx   = s_addr_i[IDX_W+1:2];
  assign s_tag   = s_addr_i[31:IDX_W+2];
  assign r_idx   = req_addr_q[IDX_W+1:2];
  assign r_tag   = req_addr_q[31:IDX_W+2];
  assign s_is_rd = (s_wstrb_i == 4'b0000);
  assign s_hit   = valid_q[s_idx] && (tag_mem[s_idx] == s_tag) && is_cacheable(s_addr_i);
  assign r_hit   = valid_q[r_idx] && (tag_mem[r_idx] == r_tag) && is_cacheable(req_addr_q);

  // Downstream request is simply "busy"; address/data/strobes come straight from the request latch.
  assign m_valid_o = (state_q != ST_IDLE);
  assign m_addr_o  = req_addr_q;
  assign m_wdata_o = req_wdata_q;
  assign m_wstrb_o = req_wstrb_q;

  always_comb begin
    merged = data_mem[r_idx];
    for (int b = 0; b < 4; b++) begin
      if (req_wstrb_q[b]) merged[8*b +: 8] = req_wdata_q[8*b +: 8];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    s_rdata_o = 32'h0;
    accept    = 1'b0;
    fill_en   = 1'b0;
    merge_en  = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A flush cycle defers any pending request by one cycle.
        if (s_valid_i && !flush_i) begin
          if (s_is_rd && s_hit) begin
            s_ready_o = 1'b1;
            s_rdata_o = data_mem[s_idx];
            hit_evt   = 1'b1;
          end else begin
            accept   = 1'b1;
            state_d  = s_is_rd ? ST_RD : ST_WR;
            miss_evt = s_is_rd && is_cacheable(s_addr_i);
          end
        end
      end
      ST_RD: begin
        if (m_ready_i) begin
          s_ready_o = 1'b1;
          s_rdata_o = m_rdata_i;
          state_d   = ST_IDLE;
          fill_en   = is_cacheable(req_addr_q) && !drop_q && !flush_i;
        end
      end
      ST_WR: begin
        if (m_ready_i) begin
          s_ready_o = 1'b1;
          state_d   = ST_IDLE;
          merge_en  = r_hit && !flush_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'b0000;
      drop_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q  <= {s_addr_i[31:2], 2'b00};
        req_wdata_q <= s_is_rd ? 32'h0 : s_wdata_i;
        req_wstrb_q <= s_wstrb_i;
      end
      // Sticky: a flush anywhere in a pending read cancels that read's fill.
      if (state_d == ST_IDLE) drop_q <= 1'b0;
      else if (flush_i)       drop_q <= 1'b1;
      if (flush_i)      valid_q        <= '0;
      else if (fill_en) valid_q[r_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether their contents matter.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_mem[r_idx]  <= r_tag;
      data_mem[r_idx] <= m_rdata_i;
    end else if (merge_en) begin
      data_mem[r_idx] <= merged;
    end
  end

`ifdef NMI_RD_CACHE_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
  assign hit_cnt_o  = 32'h0;
  assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_nmi_rd_cache.sv
// Directed bench for nmi_rd_cache: fills, hits, write merge, conflicts, uncacheable, flush, reset.
module tb_nmi_rd_cache;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_addr_i;
  logic [31:0] s_wdata_i;
  logic [3:0]  s_wstrb_i;
  logic [31:0] s_rdata_o;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_rdata_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Downstream memory model state
  int          lat       = 3;
  int          wait_cnt  = 0;
  int          txn_cnt   = 0;
  logic [31:0] resp_data = 32'h0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;

  always #5 clk_i = ~clk_i;

  nmi_rd_cache #(
    .DEPTH(16),
    .CACHE_BASE(32'h0000_0000),
    .CACHE_MASK(32'hF000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .flush_i(flush_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i),
    .s_wstrb_i(s_wstrb_i),
    .s_rdata_o(s_rdata_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o),
    .m_rdata_i(m_rdata_i),
    .hit_cnt_o(hit_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  // Slave memory: completes each request 'lat' cycles after m_valid_o rises.
  always @(posedge clk_i) begin
    #1;
    if (m_ready_i) begin
      m_ready_i = 1'b0;
      wait_cnt  = 0;
    end else if (m_valid_o) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        m_ready_i  = 1'b1;
        m_rdata_i  = resp_data;
        txn_cnt++;
        seen_addr  = m_addr_o;
        seen_wdata = m_wdata_o;
        seen_wstrb = m_wstrb_o;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef NMI_RD_CACHE_STAT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic check_cnt(input string tag, input int hits, input int misses);
    check({tag, "_hit_cnt"},  hit_cnt_o,  exp_cnt(hits));
    check({tag, "_miss_cnt"}, miss_cnt_o, exp_cnt(misses));
  endtask

  // Core-side request; called and returns just after a rising edge. flush_at pulses flush_i
  // during that cycle index of the request (0 = no flush).
  task automatic do_req(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input int flush_at,
                        output logic [31:0] rdata, output int cycles);
    bit done = 1'b0;
    rdata     = 32'h0;
    cycles    = -1;
    s_valid_i = 1'b1;
    s_addr_i  = addr;
    s_wstrb_i = strb;
    s_wdata_i = wdata;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        rdata  = s_rdata_o;
        cycles = n;
        done   = 1'b1;
      end
      @(posedge clk_i);
      #1;
      flush_i = (n + 1 == flush_at);
    end
    s_valid_i = 1'b0;
    s_wstrb_i = 4'b0000;
    flush_i   = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] resp,
                    input logic [31:0] exp_data, input bit exp_miss, input int flush_at = 0);
    logic [31:0] data;
    int          cycles;
    int          t0 = txn_cnt;
    resp_data = resp;
    do_req(tag, addr, 4'b0000, 32'h0, flush_at, data, cycles);
    check({tag, "_rdata"}, data, exp_data);
    check({tag, "_m_txns"}, 32'(txn_cnt - t0), exp_miss ? 32'd1 : 32'd0);
    check({tag, "_zero_wait"}, 32'(cycles == 0), exp_miss ? 32'd0 : 32'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                    input logic [31:0] wdata);
    logic [31:0] data;
    int          cycles;
    int          t0 = txn_cnt;
    do_req(tag, addr, strb, wdata, 0, data, cycles);
    check({tag, "_m_txns"}, 32'(txn_cnt - t0), 32'd1);
    check({tag, "_m_addr"}, seen_addr, {addr[31:2], 2'b00});
    check({tag, "_m_wstrb"}, {28'h0, seen_wstrb}, {28'h0, strb});
    check({tag, "_m_wdata"}, seen_wdata, wdata);
  endtask

  initial begin
    rst_n_i   = 1'b0;
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    s_addr_i  = 32'h0;
    s_wdata_i = 32'h0;
    s_wstrb_i = 4'b0000;
    m_ready_i = 1'b0;
    m_rdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check("rst_s_ready", {31'h0, s_ready_o}, 32'h0);
    check("rst_s_rdata", s_rdata_o, 32'h0);
    check("rst_m_valid", {31'h0, m_valid_o}, 32'h0);
    check("rst_m_addr", m_addr_o, 32'h0);
    check("rst_m_wdata", m_wdata_o, 32'h0);
    check("rst_m_wstrb", {28'h0, m_wstrb_o}, 32'h0);
    check_cnt("rst", 0, 0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill then hit
    lat = 3;
    rd("fill_10", 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    check("fill_10_m_addr", seen_addr, 32'h0000_0010);
    check("fill_10_m_wstrb", {28'h0, seen_wstrb}, 32'h0);
    rd("hit_10", 32'h0000_0010, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 1'b0);
    check_cnt("after_hit", 1, 1);

    // Write-through with byte merge into a cached line
    lat = 2;
    wr("wr_10", 32'h0000_0010, 4'b0011, 32'h0000_1234);
    rd("merged_10", 32'h0000_0010, 32'h0BAD_0BAD, 32'hDEAD_1234, 1'b0);

    // Index conflict: 0x50 evicts 0x10
    rd("conf_50", 32'h0000_0050, 32'h5555_5555, 32'h5555_5555, 1'b1);
    rd("conf_10", 32'h0000_0010, 32'h1111_1111, 32'h1111_1111, 1'b1);
    rd("conf_10_hit", 32'h0000_0010, 32'h0BAD_0BAD, 32'h1111_1111, 1'b0);

    // Uncacheable region: always downstream, no fill, no miss count
    rd("unc_1", 32'h1000_0003, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    check("unc_1_m_addr", seen_addr, 32'h1000_0000);
    rd("unc_2", 32'h1000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);
    check_cnt("after_unc", 3, 3);

    // Write miss does not allocate
    wr("wr_30", 32'h0000_0030, 4'b1111, 32'hAAAA_AAAA);
    rd("after_wr_30", 32'h0000_0030, 32'h3030_3030, 32'h3030_3030, 1'b1);

    // Flush while a fill is pending: data delivered, line not filled, other lines gone
    lat = 4;
    rd("flush_rd_20", 32'h0000_0020, 32'h2020_2020, 32'h2020_2020, 1'b1, 2);
    lat = 2;
    rd("reread_20", 32'h0000_0020, 32'h2020_2020, 32'h2020_2020, 1'b1);
    rd("reread_10", 32'h0000_0010, 32'h1010_1010, 32'h1010_1010, 1'b1);
    rd("hit_20", 32'h0000_0020, 32'h0BAD_0BAD, 32'h2020_2020, 1'b0);
    rd("hit_10b", 32'h0000_0010, 32'h0BAD_0BAD, 32'h1010_1010, 1'b0);

    // Flush in IDLE invalidates everything
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    rd("idle_flush_10", 32'h0000_0010, 32'h7777_0010, 32'h7777_0010, 1'b1);
    rd("idle_flush_20", 32'h0000_0020, 32'h7777_0020, 32'h7777_0020, 1'b1);
    check_cnt("after_flush", 5, 9);

    // Asynchronous reset in the middle of a write
    lat       = 1000;
    s_valid_i = 1'b1;
    s_addr_i  = 32'h0000_0020;
    s_wstrb_i = 4'b1111;
    s_wdata_i = 32'h5A5A_5A5A;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("midwr_m_valid", {31'h0, m_valid_o}, 32'h1);
    check("midwr_m_wstrb", {28'h0, m_wstrb_o}, 32'hF);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("arst_m_valid", {31'h0, m_valid_o}, 32'h0);
    check("arst_s_ready", {31'h0, s_ready_o}, 32'h0);
    check("arst_m_addr", m_addr_o, 32'h0);
    check("arst_m_wstrb", {28'h0, m_wstrb_o}, 32'h0);
    check("arst_m_wdata", m_wdata_o, 32'h0);
    check_cnt("arst", 0, 0);
    s_valid_i = 1'b0;
    s_wstrb_i = 4'b0000;
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    lat     = 2;
    @(posedge clk_i);
    #1;
    rd("post_rst_10", 32'h0000_0010, 32'h9999_0010, 32'h9999_0010, 1'b1);
    check_cnt("post_rst", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
